alu_result_writeback: RTL

ALU_RESULT_WRITEBACK -- requirements
Module: alu_result_writeback

---
 rtl/alu_result_writeback.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
//   Takes a 2*DW-bit ALU result and drives it onto a DW-bit datapath bus.
//   Single-word ops produce one low-word beat. mul/div produce a low beat and
//   then a high beat, and also load the architectural HI/LO registers.
//   mfhi/mflo requests (rd_req) replay HI or LO as a single beat.
//   An unsupported opcode is consumed with a one-cycle err_op pulse.
//
// Ports
//   clk, clear            rising-edge clock, synchronous active-high reset
//   res_valid/res_ready   result handshake (ready only in IDLE)
//   res_data, res_op      result word {high, low} and producing opcode
//   rd_req, rd_sel        move-from request, 0 = LO, 1 = HI
//   bus_valid/bus_ready   output beat handshake
//   bus_data, bus_hi      beat payload; bus_hi marks a high word or HI
//   hi_q, lo_q            HI/LO registers
//   err_op                one-cycle pulse after an unsupported opcode
// ---------------------------------------------------------------------------
module alu_result_writeback #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [2*DW-1:0] res_data,
    input  logic [4:0]      res_op,
    input  logic            rd_req,
    input  logic            rd_sel,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic [DW-1:0]   bus_data,
    output logic            bus_hi,
    output logic [DW-1:0]   hi_q,
    output logic [DW-1:0]   lo_q,
    output logic            err_op
);

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_MV} state_t;

    localparam logic [4:0] OP_FIRST = 5'b00011;  // add
    localparam logic [4:0] OP_LAST  = 5'b10010;  // not
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;

    state_t          r_state;
    logic [DW-1:0]   r_zhi;
    logic [DW-1:0]   r_zlo;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic [DW-1:0]   r_mv_data;
    logic            r_mv_sel;
    logic            r_md;       // current result is mul/div (two beats)
    logic            r_pend;     // rd_req lost to a simultaneous result
    logic            r_pend_sel;
    logic            r_err;

    logic            w_sup;
    logic            w_md;
    logic            w_sel;

    assign w_sup = (res_op >= OP_FIRST) && (res_op <= OP_LAST);
    assign w_md  = (res_op == OP_MUL) || (res_op == OP_DIV);
    // A parked request keeps the select it was issued with.
    assign w_sel = r_pend ? r_pend_sel : rd_sel;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= IDLE;
            r_zhi      <= '0;
            r_zlo      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mv_data  <= '0;
            r_mv_sel   <= 1'b0;
            r_md       <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_sel <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (res_valid) begin
                        // Result wins; remember a colliding move-from.
                        if (rd_req && !r_pend) begin
                            r_pend     <= 1'b1;
                            r_pend_sel <= rd_sel;
                        end
                        if (w_sup) begin
                            r_zhi   <= res_data[2*DW-1:DW];
                            r_zlo   <= res_data[DW-1:0];
                            r_md    <= w_md;
                            r_state <= SEND_LO;
                            if (w_md) begin
                                r_hi <= res_data[2*DW-1:DW];
                                r_lo <= res_data[DW-1:0];
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (rd_req || r_pend) begin
                        r_pend    <= 1'b0;
                        r_mv_sel  <= w_sel;
                        r_mv_data <= w_sel ? r_hi : r_lo;
                        r_state   <= SEND_MV;
                    end
                end
                SEND_LO: begin
                    if (bus_ready) r_state <= r_md ? SEND_HI : IDLE;
                end
                SEND_HI, SEND_MV: begin
                    if (bus_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign res_ready = (r_state == IDLE);
    assign bus_valid = (r_state != IDLE);
    assign bus_hi    = (r_state == SEND_HI) || ((r_state == SEND_MV) && r_mv_sel);
    assign hi_q      = r_hi;
    assign lo_q      = r_lo;
    assign err_op    = r_err;

    always_comb begin
        bus_data = '0;
        case (r_state)
            SEND_LO: bus_data = r_zlo;
            SEND_HI: bus_data = r_zhi;
            SEND_MV: bus_data = r_mv_data;
            default: bus_data = '0;
        endcase
    end

endmodule
